// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared nRISC widths and data memory dumper state encoding
package nrisc_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_FETCH = 2'd1,
    DUMP_SEND  = 2'd2,
    DUMP_DONE  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/data_memory_dumper_if.sv
// rtl/data_memory_dumper_if.sv - data memory read port plus output byte stream of the dumper
interface data_memory_dumper_if #(
  parameter int ADDR_WIDTH = nrisc_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = nrisc_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  memwrite;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_address,
    output memwrite,
    output out_data,
    output out_valid,
    output out_last,
    input  mem_read_data,
    input  out_ready
  );

  modport slave (
    input  mem_address,
    input  memwrite,
    input  out_data,
    input  out_valid,
    input  out_last,
    output mem_read_data,
    output out_ready
  );

endinterface

// File: rtl/data_memory_dumper.sv
// rtl/data_memory_dumper.sv - walks a data memory address range and streams each byte out
module data_memory_dumper
  import nrisc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  data_memory_dumper_if.master  dif,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = DUMP_IDLE;
  localparam logic [1:0] S_FETCH = DUMP_FETCH;
  localparam logic [1:0] S_SEND  = DUMP_SEND;
  localparam logic [1:0] S_DONE  = DUMP_DONE;

  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;

  // remaining is one bit wider than the address so a 256-byte dump visits every address once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      address   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              address   <= start_address;
              remaining <= count;
              state     <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            data_q  <= dif.mem_read_data;
            valid_q <= 1'b1;
            last_q  <= (remaining == REM_ONE);
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          // abort outranks a same-cycle handshake: the beat is gone but no done follows
          if (abort) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (dif.out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (remaining == REM_ONE) begin
              state <= S_DONE;
            end else begin
              address   <= ADDR_WIDTH'(address + 1'b1);
              remaining <= (ADDR_WIDTH + 1)'(remaining - 1'b1);
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dif.mem_address = address;
  assign dif.memwrite    = 1'b0;
  assign dif.out_data    = data_q;
  assign dif.out_valid   = valid_q;
  assign dif.out_last    = last_q;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_data_memory_dumper.sv
// tb/tb_data_memory_dumper.sv - self-checking bench for data_memory_dumper with a beat scoreboard
module tb_data_memory_dumper;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] start_address;
  logic [8:0] count;
  logic       abort;
  logic       busy;
  logic       done;

  data_memory_dumper_if dif ();

  data_memory_dumper dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .count         (count),
    .abort         (abort),
    .dif           (dif),
    .busy          (busy),
    .done          (done)
  );

  logic [7:0] mem [256];
  assign dif.mem_read_data = mem[dif.mem_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] addr;
  } beat_t;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] cnt;
    int         rmode;
    logic [7:0] pre [3];
    int         lat;
  } vec_t;

  beat_t exp_q [$];
  vec_t  vecs [7];
  int    checks;
  int    errors;
  int    done_seen;
  int    rmode;
  logic  saw_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
    if (rmode == 0) dif.out_ready = 1'b1;
    else if (rmode == 1) dif.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sample();
    beat_t e;
    @(negedge clock);
    saw_done = done;
    if (done) done_seen++;
    if (dif.out_valid && dif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, required no beat", dif.out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", dif.out_data, e.data);
        check("beat_last", dif.out_last, e.last);
        check("beat_addr", dif.mem_address, e.addr);
        check("memwrite", dif.memwrite, 0);
      end
    end
  endtask

  task automatic cycle();
    to_next();
    sample();
  endtask

  task automatic push_expected(input logic [7:0] a, input logic [8:0] c);
    beat_t e;
    logic [7:0] ad;
    for (int i = 0; i < int'(c); i++) begin
      ad     = a + 8'(i);
      e.addr = ad;
      e.data = mem[ad];
      e.last = (i == int'(c) - 1);
      exp_q.push_back(e);
    end
  endtask

  // start is raised in the cycle after the last sample; lat counts cycles from that accepting cycle to done
  task automatic run_dump(input logic [7:0] a, input logic [8:0] c, input int mode,
                          input int exp_lat, input int poke_at);
    int lat;
    int budget;
    rmode = mode;
    push_expected(a, c);
    start_address = a;
    count         = c;
    start         = 1'b1;
    lat           = -1;
    budget        = int'(c) * 8 + 20;
    for (int n = 1; n <= budget; n++) begin
      to_next();
      start = (n == poke_at);
      if (start) begin
        count         = 9'd0;
        start_address = 8'h50;
      end
      sample();
      if (saw_done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check("done_reached", (lat >= 0), 1);
    if (exp_lat >= 0) check("done_latency", lat, exp_lat);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    cycle();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int ds;
    checks        = 0;
    errors        = 0;
    done_seen     = 0;
    saw_done      = 1'b0;
    rmode         = 0;
    reset         = 1'b0;
    start         = 1'b0;
    start_address = 8'h00;
    count         = 9'd0;
    abort         = 1'b0;
    dif.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29) ^ 8'hC3;

    vecs[0] = '{8'h00, 9'd2,  0, '{8'h02, 8'h0A, 8'h00}, 5};
    vecs[1] = '{8'hFE, 9'd3,  0, '{8'h11, 8'h22, 8'h33}, 7};
    vecs[2] = '{8'h00, 9'd0,  0, '{8'h00, 8'h00, 8'h00}, 1};
    vecs[3] = '{8'h40, 9'd1,  0, '{8'h5C, 8'h00, 8'h00}, 3};
    vecs[4] = '{8'h80, 9'd5,  1, '{8'hA1, 8'hB2, 8'hC3}, -1};
    vecs[5] = '{8'hF0, 9'd20, 1, '{8'h0F, 8'hE1, 8'h7E}, -1};
    vecs[6] = '{8'h7F, 9'd4,  0, '{8'h99, 8'h88, 8'h77}, 9};

    #3;
    check("rst_mem_address", dif.mem_address, 8'h00);
    check("rst_out_data", dif.out_data, 8'h00);
    check("rst_out_valid", dif.out_valid, 0);
    check("rst_out_last", dif.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_memwrite", dif.memwrite, 0);
    to_next();
    reset = 1'b1;
    sample();

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j < int'(vecs[i].cnt)) mem[vecs[i].addr + 8'(j)] = vecs[i].pre[j];
      end
      run_dump(vecs[i].addr, vecs[i].cnt, vecs[i].rmode, vecs[i].lat, 0);
    end

    // consumer stalls three cycles on the first beat
    mem[0] = 8'h02;
    mem[1] = 8'h0A;
    rmode = 2;
    dif.out_ready = 1'b0;
    push_expected(8'h00, 9'd2);
    start_address = 8'h00;
    count = 9'd2;
    start = 1'b1;
    to_next();
    start = 1'b0;
    sample();
    check("stall_addr_k1", dif.mem_address, 8'h00);
    for (int s = 0; s < 3; s++) begin
      cycle();
      check("stall_valid", dif.out_valid, 1);
      check("stall_data", dif.out_data, 8'h02);
      check("stall_addr", dif.mem_address, 8'h00);
    end
    rmode = 0;
    ds = done_seen;
    for (int n = 0; n < 20 && done_seen == ds; n++) cycle();
    check("stall_done", done_seen - ds, 1);
    check("stall_queue", exp_q.size(), 0);
    exp_q.delete();
    cycle();

    // start with count 0 pulsed while a dump is in SEND must be ignored
    run_dump(8'h30, 9'd3, 0, 7, 2);

    // abort during the second beat of a 4-byte dump; that beat still reaches the consumer
    rmode = 0;
    ds = done_seen;
    push_expected(8'h10, 9'd4);
    start_address = 8'h10;
    count = 9'd4;
    start = 1'b1;
    to_next();
    start = 1'b0;
    sample();
    cycle();
    cycle();
    to_next();
    abort = 1'b1;
    sample();
    check("abort_beat_valid", dif.out_valid, 1);
    to_next();
    abort = 1'b0;
    sample();
    check("abort_valid_low", dif.out_valid, 0);
    check("abort_last_low", dif.out_last, 0);
    check("abort_busy_low", busy, 0);
    check("abort_addr_hold", dif.mem_address, 8'h11);
    check("abort_pending", exp_q.size(), 2);
    exp_q.delete();
    for (int n = 0; n < 4; n++) cycle();
    check("abort_no_done", done_seen - ds, 0);

    // asynchronous reset in the middle of a dump
    ds = done_seen;
    push_expected(8'h20, 9'd4);
    start_address = 8'h20;
    count = 9'd4;
    start = 1'b1;
    to_next();
    start = 1'b0;
    sample();
    cycle();
    cycle();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", dif.out_valid, 0);
    check("mid_rst_last", dif.out_last, 0);
    check("mid_rst_data", dif.out_data, 8'h00);
    check("mid_rst_addr", dif.mem_address, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    to_next();
    reset = 1'b1;
    sample();
    check("mid_rst_no_done", done_seen - ds, 0);
    run_dump(8'h21, 9'd3, 0, 7, 0);

    // full sweep over every address
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    run_dump(8'h00, 9'd256, 0, 513, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_dumper.md
# data_memory_dumper

- Sequential reader for the 8-bit nRISC data memory.
- On a start pulse it walks a contiguous address range, reads each byte through the memory's read port, and emits the bytes in order on a valid/ready output stream.
- Used by benches and by the debug path to dump memory contents after a program run.
- It sits beside data_memory as the read-side counterpart to the memory's write users; while it is busy it owns the address port.

## Interface

- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 8, memory/stream data width
- clock  in  1  single system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin dump; sampled only in IDLE
- start_address  in  ADDR_WIDTH  first address to read
- count  in  ADDR_WIDTH+1  number of bytes, 0..256; 0 = no-op
- abort  in  1  synchronous cancel of a dump in progress
- mem_address  out  ADDR_WIDTH  address presented to data_memory
- mem_read_data  in  DATA_WIDTH  data_memory read output; combinational in address
- memwrite  out  1  memory write enable; constant 0
- out_data  out  DATA_WIDTH  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- out_last  out  1  marks final beat; qualified by out_valid
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at normal completion

## Operation

- FSM states: IDLE, FETCH, SEND, DONE.
- **IDLE**
  - start=1 and count!=0: latch mem_address=start_address and remaining=count; go to FETCH.
  - start=1 and count=0: go to DONE.
  - start=0: stay in IDLE.
- **FETCH** (one cycle)
  - At the end of the cycle, register out_data=mem_read_data, set out_valid=1, set out_last=(remaining==1); go to SEND.
- **SEND**
  - Hold out_data, out_last, out_valid and mem_address stable while out_ready=0.
  - On handshake with remaining==1: clear out_valid and out_last; go to DONE.
  - On handshake otherwise: mem_address+1 (8-bit wrap, 0xFF→0x00), remaining−1; clear out_valid; go to FETCH.
- **DONE**
  - done=1 for exactly this cycle; go to IDLE.
- start while busy is ignored; count and start_address are sampled only on the accepting edge.
- abort=1 in FETCH or SEND:
  - next state is IDLE;
  - out_valid and out_last clear;
  - no done pulse;
  - mem_address holds its last value.
- abort in IDLE or DONE has no effect.
- abort and a same-cycle handshake: abort wins; the beat counts as delivered to the consumer, but no done pulse is produced.
- remaining is ADDR_WIDTH+1 bits so that count=256 reads all addresses exactly once.

## Timing

- Reset values (asynchronous, with reset low): state IDLE, mem_address 0, out_data 0, out_valid 0, out_last 0, busy 0, done 0, memwrite 0.
- Reset asserted mid-dump returns everything to reset values immediately; no done pulse.
- start accepted in cycle k:
  - mem_address valid in cycle k+1;
  - out_valid high in cycle k+2.
- Peak throughput: one beat per 2 cycles (FETCH + SEND) with out_ready held high.
- Last handshake in cycle m: done=1 in cycle m+1, busy=0 in cycle m+2.
- count=0 accepted in cycle k: done=1 in cycle k+1, and out_valid never rises.
- The earliest next start is accepted in the cycle busy returns low.

## Structure

- Shared package nrisc_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults;
  - the dumper state enum (IDLE/FETCH/SEND/DONE).
- The block is a single module, with no sub-module: FSM, address counter and remaining counter are all local.
- The memory is not instantiated inside the block; the top level muxes mem_address and memwrite between the dumper (when busy=1) and the CPU.

## Test plan

- Preload mem[0]=0x02, mem[1]=0x0A; start_address=0, count=2, out_ready=1 → beats 0x02 then 0x0A two cycles apart, out_last on the second beat, done one cycle later.
- Same preload; out_ready=0 for 3 cycles at the first beat → out_data stays 0x02 and mem_address stays 0 until the handshake; then 0x0A follows.
- mem[0xFE..0x00]=0x11,0x22,0x33; start_address=0xFE, count=3 → mem_address sequence FE, FF, 00; beats 0x11, 0x22, 0x33.
- count=0 → no out_valid; done exactly one cycle after start; start pulsed while busy is ignored.
- Full sweep: start_address=0, count=256, mem[i]=i → 256 beats 0x00..0xFF; out_last only on 0xFF; memwrite stays 0 throughout.
- Cancel cases:
  - abort during the second beat of a 4-byte dump → out_valid drops next cycle, no done, busy low;
  - reset low mid-dump → all outputs at reset values, and a fresh start afterwards works.
